writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: DATA_W, 16, datapath and register width; SHALL be fixed at 16 for this design.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: iswb  input  1  instruction in this stage writes a register.
REQ-005 Port: isld  input  1  instruction is a load; selects load data.
REQ-006 Port: instr  input  16  instruction word; destination register = instr[10:8].
REQ-007 Port: aluresult  input  16  ALU result delivered by the memory stage.
REQ-008 Port: ldresult  input  16  load data delivered by the memory stage.
REQ-009 Port: rs1_addr  input  3  read-port-1 register index.
REQ-010 Port: rs2_addr  input  3  read-port-2 register index.
REQ-011 Port: rs1_val  output  16  read-port-1 data, combinational.
REQ-012 Port: rs2_val  output  16  read-port-2 data, combinational.
REQ-013 Port: wb_valid  output  1  registered: a write was committed last cycle.
REQ-014 Port: wb_rd  output  3  registered destination of last committed write.
REQ-015 Port: wb_data  output  16  registered data of last committed write.
REQ-016 Port: rdvalwb  output  20  registered forwarding bus {wb_valid, wb_data, wb_rd}.
REQ-017 Port: retire_count  output  16  registered count of committed writebacks.

Function
REQ-018 Write data SHALL be ldresult when isld=1, else aluresult; isld with iswb=0 SHALL write nothing.
REQ-019 Register file SHALL hold 8 x 16-bit registers R0..R7.
REQ-020 When iswb=1 and reset=0, R[instr[10:8]] SHALL take the write data at the same posedge.
REQ-021 R0 SHALL always read 0; writes to R0 SHALL be discarded but still count as committed.
REQ-022 rsN_val SHALL equal R[rsN_addr] combinationally, except: if iswb=1, reset=0, rsN_addr=instr[10:8] and rsN_addr!=0, rsN_val SHALL equal the current write data (write-through bypass).
REQ-023 Both read ports SHALL operate independently; equal addresses SHALL return identical data.
REQ-024 wb_valid, wb_rd, wb_data SHALL register iswb, instr[10:8], write data each cycle (latency 1); when iswb=0, wb_valid=0 and wb_rd/wb_data SHALL be 0.
REQ-025 rdvalwb SHALL equal {wb_valid, wb_data, wb_rd} bit-for-bit (bit 19 = valid, bits 18:3 = data, bits 2:0 = rd).
REQ-026 retire_count SHALL increment by 1 per cycle with iswb=1 and reset=0, wrapping 0xFFFF -> 0x0000.
REQ-027 Back-to-back writes to the same register SHALL leave the later value; no stall or backpressure exists.

Reset
REQ-028 With reset=1 at posedge: R0..R7 <= 0, wb_valid <= 0, wb_rd <= 0, wb_data <= 0, retire_count <= 0.
REQ-029 A write presented in a reset cycle SHALL be dropped and SHALL NOT bypass to rsN_val.
REQ-030 After reset deasserts, the first posedge SHALL accept writes normally.

Verification
REQ-031 Reset, then iswb=1, isld=0, instr[10:8]=3, aluresult=0x1234 -> next cycle R3=0x1234, rdvalwb=0x891A3 ({1,0x1234,3}), retire_count=1.
REQ-032 iswb=1, isld=1, instr[10:8]=5, ldresult=0xBEEF, aluresult=0x0007, rs1_addr=5 -> same cycle rs1_val=0xBEEF (bypass); next cycle R5=0xBEEF, wb_data=0xBEEF.
REQ-033 iswb=1, instr[10:8]=0, aluresult=0xFFFF; rs1_addr=rs2_addr=0 -> rs1_val=rs2_val=0 always; wb_valid=1, wb_rd=0; retire_count increments.
REQ-034 Preload retire_count to 0xFFFF via 65535 writes, one more write -> retire_count=0x0000.
REQ-035 R2=0x00AA, then reset=1 with iswb=1, instr[10:8]=2, aluresult=0x5555 -> R2=0, rs1_val(rs1_addr=2)=0x00AA during the reset cycle, retire_count=0, wb_valid=0.
REQ-036 isld=1, iswb=0, instr[10:8]=4, ldresult=0x1111 -> R4 unchanged, wb_valid=0, rdvalwb=0x00000, retire_count unchanged.

Source files
------------

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit: 8x16 register file with write-through read bypass,
// registered writeback/forwarding bus and retire counter.   Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iswb,
  input  logic              isld,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] aluresult,
  input  logic [DATA_W-1:0] ldresult,
  input  logic [2:0]        rs1_addr,
  input  logic [2:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W+3:0] rdvalwb,
  output logic [DATA_W-1:0] retire_count
);

  localparam int C_NREGS = 8;

  logic [DATA_W-1:0] rf_q [C_NREGS];
  logic              wb_valid_q, wb_valid_d;
  logic [2:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] count_q, count_d;

  logic [2:0]        w_rd;
  logic [DATA_W-1:0] w_wdata;
  logic              w_bypass1;
  logic              w_bypass2;
  logic              w_unused_instr;

  assign w_rd           = instr[10:8];
  assign w_wdata        = isld ? ldresult : aluresult;
  assign w_unused_instr = ^{instr[DATA_W-1:11], instr[7:0]};

  // A write in a reset cycle is dropped, so it must not be seen by readers either.
  assign w_bypass1 = iswb && !reset && (rs1_addr == w_rd) && (rs1_addr != 3'd0);
  assign w_bypass2 = iswb && !reset && (rs2_addr == w_rd) && (rs2_addr != 3'd0);

  assign rs1_val = (rs1_addr == 3'd0) ? '0 : (w_bypass1 ? w_wdata : rf_q[rs1_addr]);
  assign rs2_val = (rs2_addr == 3'd0) ? '0 : (w_bypass2 ? w_wdata : rf_q[rs2_addr]);

  always_comb begin
    wb_valid_d = iswb;
    wb_rd_d    = iswb ? w_rd : 3'd0;
    wb_data_d  = iswb ? w_wdata : '0;
    count_d    = count_q + {{(DATA_W-1){1'b0}}, iswb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_NREGS; i++) begin
        rf_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= '0;
      count_q    <= '0;
    end else begin
      // R0 writes are discarded but still retire.
      if (iswb && (w_rd != 3'd0)) begin
        rf_q[w_rd] <= w_wdata;
      end
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      count_q    <= count_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign rdvalwb      = {wb_valid_q, wb_data_q, wb_rd_q};
  assign retire_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit: directed vectors with a per-cycle expected-output queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iswb = 1'b0;
  logic        isld = 1'b0;
  logic [15:0] instr = 16'h0;
  logic [15:0] aluresult = 16'h0;
  logic [15:0] ldresult = 16'h0;
  logic [2:0]  rs1_addr = 3'd0;
  logic [2:0]  rs2_addr = 3'd0;
  logic [15:0] rs1_val, rs2_val, wb_data, retire_count;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [19:0] rdvalwb;

  writeback_unit #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .iswb(iswb), .isld(isld), .instr(instr),
    .aluresult(aluresult), .ldresult(ldresult),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rdvalwb(rdvalwb), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] rv;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_rf [8];
  logic [15:0] exp_cnt = 16'h0;
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] a, input logic r, input logic wb,
                                           input logic [2:0] rd, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0;
    if (wb && !r && a == rd) return wd;
    return exp_rf[a];
  endfunction

  // One clock of stimulus; combinational reads are checked before the edge,
  // then the expected registered outputs for that edge are queued.
  task automatic step(input string name, input logic r, input logic wb, input logic ld,
                      input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] ldr,
                      input logic [2:0] a1, input logic [2:0] a2);
    logic [15:0] wd;
    exp_t        e;
    wd        = ld ? ldr : alu;
    reset     = r;
    iswb      = wb;
    isld      = ld;
    instr     = {5'b10110, rd, 8'hA5};
    aluresult = alu;
    ldresult  = ldr;
    rs1_addr  = a1;
    rs2_addr  = a2;
    #1;
    chk({name, ".rs1"}, {16'h0, rs1_val}, {16'h0, exp_read(a1, r, wb, rd, wd)});
    chk({name, ".rs2"}, {16'h0, rs2_val}, {16'h0, exp_read(a2, r, wb, rd, wd)});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;
      exp_cnt = 16'h0;
      e.rv    = 20'h0;
    end else if (wb) begin
      if (rd != 3'd0) exp_rf[rd] = wd;
      exp_cnt = exp_cnt + 16'h1;
      e.rv    = {1'b1, wd, rd};
    end else begin
      e.rv    = 20'h0;
    end
    e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input string name, input logic [2:0] a1, input logic [2:0] a2);
    step(name, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, a1, a2);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (rdvalwb !== e.rv || retire_count !== e.cnt || wb_valid !== e.rv[19] ||
          wb_data !== e.rv[18:3] || wb_rd !== e.rv[2:0]) begin
        n_fail++;
        $display("FAIL wb_out: got rdvalwb=0x%0h cnt=0x%0h v=%0b d=0x%0h rd=%0d, expected rdvalwb=0x%0h cnt=0x%0h",
                 rdvalwb, retire_count, wb_valid, wb_data, wb_rd, e.rv, e.cnt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;
    @(posedge clk);
    #1;
    step("rst0", 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd1, 3'd7);
    step("rst1", 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 3'd2, 3'd6);
    chk("rst.rdvalwb", {12'h0, rdvalwb}, 32'h0);
    chk("rst.count", {16'h0, retire_count}, 32'h0);

    // ALU write to R3
    step("alu_r3", 1'b0, 1'b1, 1'b0, 3'd3, 16'h1234, 16'hDEAD, 3'd3, 3'd4);
    chk("alu_r3.rdvalwb", {12'h0, rdvalwb}, 32'h891A3);
    chk("alu_r3.count", {16'h0, retire_count}, 32'h1);
    idle("rd_r3", 3'd3, 3'd3);
    chk("rd_r3.val", {16'h0, rs1_val}, 32'h1234);

    // load write to R5 with bypass
    step("ld_r5", 1'b0, 1'b1, 1'b1, 3'd5, 16'h0007, 16'hBEEF, 3'd5, 3'd3);
    chk("ld_r5.wb_data", {16'h0, wb_data}, 32'hBEEF);
    idle("rd_r5", 3'd5, 3'd5);
    chk("rd_r5.val", {16'h0, rs2_val}, 32'hBEEF);

    // write to R0 is discarded but retires
    step("r0", 1'b0, 1'b1, 1'b0, 3'd0, 16'hFFFF, 16'h0, 3'd0, 3'd0);
    chk("r0.rdvalwb", {12'h0, rdvalwb}, 32'hFFFF8);
    chk("r0.count", {16'h0, retire_count}, 32'h3);
    idle("rd_r0", 3'd0, 3'd0);

    // back-to-back to R6
    step("b2b_a", 1'b0, 1'b1, 1'b0, 3'd6, 16'h0101, 16'h0, 3'd6, 3'd1);
    step("b2b_b", 1'b0, 1'b1, 1'b0, 3'd6, 16'h0202, 16'h0, 3'd1, 3'd6);
    idle("rd_r6", 3'd6, 3'd5);
    chk("rd_r6.val", {16'h0, rs1_val}, 32'h0202);

    // load without writeback
    step("ld_nowb", 1'b0, 1'b0, 1'b1, 3'd4, 16'h0, 16'h1111, 3'd4, 3'd4);
    chk("ld_nowb.rdvalwb", {12'h0, rdvalwb}, 32'h0);
    chk("ld_nowb.count", {16'h0, retire_count}, 32'h5);
    idle("rd_r4", 3'd4, 3'd2);

    // write dropped in reset cycle, no bypass
    step("r2", 1'b0, 1'b1, 1'b0, 3'd2, 16'h00AA, 16'h0, 3'd7, 3'd2);
    step("rst_wr", 1'b1, 1'b1, 1'b0, 3'd2, 16'h5555, 16'h0, 3'd2, 3'd2);
    chk("rst_wr.count", {16'h0, retire_count}, 32'h0);
    chk("rst_wr.valid", {31'h0, wb_valid}, 32'h0);
    idle("rd_r2", 3'd2, 3'd5);
    chk("rd_r2.val", {16'h0, rs1_val}, 32'h0);

    // first cycle after reset accepts writes
    step("post_rst", 1'b0, 1'b1, 1'b0, 3'd1, 16'h7777, 16'h0, 3'd1, 3'd0);
    chk("post_rst.count", {16'h0, retire_count}, 32'h1);

    // drive the retire counter to 0xFFFF, then wrap
    for (int i = 0; i < 65534; i++) begin
      step("fill", 1'b0, 1'b1, i[0], 3'd7, i[15:0], ~i[15:0], 3'd7, 3'd1);
    end
    chk("fill.count", {16'h0, retire_count}, 32'hFFFF);
    step("wrap", 1'b0, 1'b1, 1'b0, 3'd7, 16'hC0DE, 16'h0, 3'd7, 3'd6);
    chk("wrap.count", {16'h0, retire_count}, 32'h0);
    idle("rd_r7", 3'd7, 3'd1);
    chk("rd_r7.val", {16'h0, rs1_val}, 32'hC0DE);

    @(negedge clk);
    @(negedge clk);
    chk("sb.drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
